// File: rtl/wb_host_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_host_pkg : shared types and constants for the Wishbone host master
// Revision 1.0
// ------------------------------------------------------------------
package wb_host_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      WR_BUS  = 3'd2,
      RD_BUS  = 3'd3,
      RD_HOLD = 3'd4,
      DONE    = 3'd5
   } state_e;

   localparam int   SLAVE_SEL_MSB = 31;
   localparam int   SLAVE_SEL_LSB = 24;
   localparam int   OFFSET_W      = 24;
   localparam logic RSP_OK        = 1'b0;
   localparam logic RSP_TIMEOUT   = 1'b1;

   // Offset wraps inside its own field; the slave select never changes.
   function automatic logic [31:0] next_adr(input logic [31:0] adr);
      logic [OFFSET_W-1:0] off;
      off = adr[OFFSET_W-1:0] + OFFSET_W'(1);
      return {adr[SLAVE_SEL_MSB:SLAVE_SEL_LSB], off};
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_timeout_counter : counts un-acked strobe cycles, flags the limit
// Revision 1.0
// ------------------------------------------------------------------
module wb_timeout_counter #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires during the TIMEOUT-th un-acked strobe cycle.
   assign expire_o = en_i && (cnt_q >= (TIMEOUT - 16'd1));

endmodule
`default_nettype wire

// File: rtl/wb_host_master.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_host_master : host command to sequential Wishbone classic cycles
// Revision 1.0
// ------------------------------------------------------------------
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'd1000,
   parameter int          CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_stb,
   output logic             o_cmd_rdy,
   input  logic             i_cmd_wr,
   input  logic [31:0]      i_cmd_adr,
   input  logic [CNT_W-1:0] i_cmd_len,
   input  logic             i_wr_stb,
   input  logic [31:0]      i_wr_dat,
   output logic             o_wr_rdy,
   output logic             o_rd_stb,
   output logic [31:0]      o_rd_dat,
   input  logic             i_rd_rdy,
   output logic             o_rsp_stb,
   output logic             o_rsp_err,
   output logic [CNT_W-1:0] o_rsp_cnt,
   output logic             o_int_stb,
   output logic             o_m_we,
   output logic             o_m_stb,
   output logic             o_m_cyc,
   output logic [3:0]       o_m_sel,
   output logic [31:0]      o_m_adr,
   output logic [31:0]      o_m_dat,
   input  logic [31:0]      i_m_dat,
   input  logic             i_m_ack,
   input  logic             i_m_int
);

   state_e           state_q;
   logic [CNT_W-1:0] len_q, cnt_q, cnt_d, rsp_cnt_q;
   logic [31:0]      adr_q, m_dat_q, rd_dat_q;
   logic             err_q, cmd_rdy_q, wr_rdy_q, rd_stb_q;
   logic             rsp_stb_q, rsp_err_q;
   logic             m_cyc_q, m_stb_q, m_we_q;
   logic [3:0]       m_sel_q;
   logic             int_q;
   logic             bus_st, tmo_clr, tmo_en, tmo_expire;

   assign cnt_d   = cnt_q + CNT_W'(1);
   assign bus_st  = (state_q == WR_BUS) || (state_q == RD_BUS);
   assign tmo_clr = bus_st && !m_stb_q;
   assign tmo_en  = m_stb_q && !i_m_ack;

   wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         rsp_cnt_q <= '0;
         adr_q     <= '0;
         m_dat_q   <= '0;
         rd_dat_q  <= '0;
         err_q     <= RSP_OK;
         cmd_rdy_q <= 1'b0;
         wr_rdy_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         rsp_stb_q <= 1'b0;
         rsp_err_q <= 1'b0;
         m_cyc_q   <= 1'b0;
         m_stb_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_sel_q   <= 4'h0;
      end else begin
         rsp_stb_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_cmd_stb && cmd_rdy_q) begin
                  cmd_rdy_q <= 1'b0;
                  adr_q     <= i_cmd_adr;
                  len_q     <= i_cmd_len;
                  cnt_q     <= '0;
                  err_q     <= RSP_OK;
                  if (i_cmd_len == '0) begin
                     state_q <= DONE;
                  end else if (i_cmd_wr) begin
                     state_q  <= WR_DATA;
                     wr_rdy_q <= 1'b1;
                  end else begin
                     state_q <= RD_BUS;
                  end
               end else begin
                  cmd_rdy_q <= 1'b1;
               end
            end
            WR_DATA: begin
               if (i_wr_stb && wr_rdy_q) begin
                  wr_rdy_q <= 1'b0;
                  m_dat_q  <= i_wr_dat;
                  state_q  <= WR_BUS;
               end
            end
            WR_BUS, RD_BUS: begin
               // First cycle in a bus state only raises the strobe.
               if (!m_stb_q) begin
                  m_cyc_q <= 1'b1;
                  m_stb_q <= 1'b1;
                  m_we_q  <= (state_q == WR_BUS);
                  m_sel_q <= 4'hF;
               end else if (i_m_ack) begin
                  m_cyc_q <= 1'b0;
                  m_stb_q <= 1'b0;
                  m_we_q  <= 1'b0;
                  m_sel_q <= 4'h0;
                  adr_q   <= next_adr(adr_q);
                  if (state_q == WR_BUS) begin
                     cnt_q <= cnt_d;
                     if (cnt_d == len_q) begin
                        state_q <= DONE;
                     end else begin
                        state_q  <= WR_DATA;
                        wr_rdy_q <= 1'b1;
                     end
                  end else begin
                     rd_dat_q <= i_m_dat;
                     rd_stb_q <= 1'b1;
                     state_q  <= RD_HOLD;
                  end
               end else if (tmo_expire) begin
                  m_cyc_q <= 1'b0;
                  m_stb_q <= 1'b0;
                  m_we_q  <= 1'b0;
                  m_sel_q <= 4'h0;
                  err_q   <= RSP_TIMEOUT;
                  state_q <= DONE;
               end
            end
            RD_HOLD: begin
               if (i_rd_rdy) begin
                  rd_stb_q <= 1'b0;
                  cnt_q    <= cnt_d;
                  state_q  <= (cnt_d == len_q) ? DONE : RD_BUS;
               end
            end
            DONE: begin
               rsp_stb_q <= 1'b1;
               rsp_err_q <= err_q;
               rsp_cnt_q <= cnt_q;
               cmd_rdy_q <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q <= 1'b0;
      end else begin
         int_q <= i_m_int;
      end
   end

   assign o_int_stb = i_m_int & ~int_q;
   assign o_cmd_rdy = cmd_rdy_q;
   assign o_wr_rdy  = wr_rdy_q;
   assign o_rd_stb  = rd_stb_q;
   assign o_rd_dat  = rd_dat_q;
   assign o_rsp_stb = rsp_stb_q;
   assign o_rsp_err = rsp_err_q;
   assign o_rsp_cnt = rsp_cnt_q;
   assign o_m_we    = m_we_q;
   assign o_m_stb   = m_stb_q;
   assign o_m_cyc   = m_cyc_q;
   assign o_m_sel   = m_sel_q;
   assign o_m_adr   = adr_q;
   assign o_m_dat   = m_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_wb_host_master : self-checking bench for wb_host_master
// Revision 1.0
// ------------------------------------------------------------------
module tb_wb_host_master;

   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_cmd_stb = 1'b0, i_cmd_wr = 1'b0;
   logic [31:0] i_cmd_adr = '0;
   logic [15:0] i_cmd_len = '0;
   logic        i_wr_stb = 1'b0;
   logic [31:0] i_wr_dat = '0;
   logic        i_rd_rdy = 1'b0;
   logic [31:0] i_m_dat = '0;
   logic        i_m_ack = 1'b0, i_m_int = 1'b0;
   logic        o_cmd_rdy, o_wr_rdy, o_rd_stb, o_rsp_stb, o_rsp_err, o_int_stb;
   logic [31:0] o_rd_dat, o_m_adr, o_m_dat;
   logic [15:0] o_rsp_cnt;
   logic        o_m_we, o_m_stb, o_m_cyc;
   logic [3:0]  o_m_sel;

   wb_host_master #(.TIMEOUT(16'(TB_TIMEOUT)), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_wr(i_cmd_wr),
      .i_cmd_adr(i_cmd_adr), .i_cmd_len(i_cmd_len),
      .i_wr_stb(i_wr_stb), .i_wr_dat(i_wr_dat), .o_wr_rdy(o_wr_rdy),
      .o_rd_stb(o_rd_stb), .o_rd_dat(o_rd_dat), .i_rd_rdy(i_rd_rdy),
      .o_rsp_stb(o_rsp_stb), .o_rsp_err(o_rsp_err), .o_rsp_cnt(o_rsp_cnt),
      .o_int_stb(o_int_stb),
      .o_m_we(o_m_we), .o_m_stb(o_m_stb), .o_m_cyc(o_m_cyc), .o_m_sel(o_m_sel),
      .o_m_adr(o_m_adr), .o_m_dat(o_m_dat), .i_m_dat(i_m_dat),
      .i_m_ack(i_m_ack), .i_m_int(i_m_int)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rdata(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] word_adr(input logic [31:0] base, input int i);
      logic [31:0] off;
      off = (32'(base[23:0]) + 32'(i)) % 32'h0100_0000;
      return {base[31:24], off[23:0]};
   endfunction

   // Words the slave model will acknowledge before the transfer ends.
   function automatic int model_words(input int len, input int dly, input int lim);
      if (len == 0) return 0;
      if (dly >= TB_TIMEOUT) return 0;
      return (lim < len) ? lim : len;
   endfunction

   // ---------------- slave model ----------------
   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
   } bus_t;

   bus_t bus_log[$];
   int   sl_delay = 0;
   int   sl_lim   = 0;
   int   sl_acks  = 0;
   int   wait_cnt = 0;
   int   stb_run  = 0;
   int   last_run = 0;

   always @(negedge clk) begin
      if (o_m_stb) begin
         stb_run++;
         wait_cnt++;
         if (wait_cnt > sl_delay && sl_acks < sl_lim) begin
            i_m_ack = 1'b1;
            i_m_dat = rdata(o_m_adr);
            bus_log.push_back('{o_m_adr, o_m_we, o_m_we ? o_m_dat : rdata(o_m_adr)});
            sl_acks++;
         end else begin
            i_m_ack = 1'b0;
            i_m_dat = $urandom;
         end
      end else begin
         i_m_ack  = 1'b0;
         wait_cnt = 0;
         if (stb_run > 0) last_run = stb_run;
         stb_run = 0;
      end
   end

   // ---------------- host-side tasks ----------------
   task automatic issue_cmd(input bit wr, input logic [31:0] adr, input int len);
      int t;
      t = 0;
      @(negedge clk);
      i_cmd_stb = 1'b1; i_cmd_wr = wr; i_cmd_adr = adr; i_cmd_len = 16'(len);
      while (!o_cmd_rdy && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_rdy", {31'b0, o_cmd_rdy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      i_cmd_stb = 1'b0;
   endtask

   task automatic run_txn(input string tag, input bit wr, input logic [31:0] adr,
                          input int len, input int dly, input int lim, input int rdw,
                          input bit eerr, input int ecnt);
      logic [31:0] wdata[$];
      logic [31:0] rdq[$];
      logic [31:0] hold_val;
      int log0, k, n, cyc, hold_cnt, viol, busy_rdy;
      bit rsp_seen, have_hold, cyc_seen, wfire, rerr;
      logic [15:0] rcnt;
      for (int i = 0; i < len; i++) wdata.push_back($urandom);
      sl_delay = dly;
      sl_lim   = sl_acks + lim;
      log0     = bus_log.size();
      k = 0; cyc = 0; hold_cnt = 0; viol = 0; busy_rdy = 0;
      rsp_seen = 0; have_hold = 0; cyc_seen = 0; rerr = 0; rcnt = '0;
      hold_val = '0;
      issue_cmd(wr, adr, len);
      while (!rsp_seen && cyc < 3000) begin
         if (o_m_cyc) cyc_seen = 1;
         if (o_rsp_stb) begin
            rsp_seen = 1;
            rerr = o_rsp_err;
            rcnt = o_rsp_cnt;
         end else begin
            if (o_cmd_rdy) busy_rdy++;
            if (wr && k < len) begin
               i_wr_stb = 1'b1;
               i_wr_dat = wdata[k];
            end else begin
               i_wr_stb = 1'b0;
            end
            wfire = i_wr_stb && o_wr_rdy;
            if (o_rd_stb) begin
               if (!have_hold) begin
                  hold_val  = o_rd_dat;
                  have_hold = 1;
               end else if (o_rd_dat !== hold_val) begin
                  viol++;
               end
               if (o_m_stb) viol++;
               if (hold_cnt < rdw) begin
                  i_rd_rdy = 1'b0;
                  hold_cnt++;
               end else begin
                  i_rd_rdy = 1'b1;
                  rdq.push_back(o_rd_dat);
                  hold_cnt  = 0;
                  have_hold = 0;
               end
            end else begin
               i_rd_rdy = 1'b0;
            end
            @(posedge clk);
            if (wfire) k++;
            @(negedge clk);
            cyc++;
         end
      end
      i_wr_stb = 1'b0;
      i_rd_rdy = 1'b0;

      n = model_words(len, dly, lim);
      chk({tag, "_rsp_seen"}, {31'b0, rsp_seen}, 32'd1);
      chk({tag, "_rsp_err"}, {31'b0, rerr}, {31'b0, eerr});
      chk({tag, "_rsp_cnt"}, {16'b0, rcnt}, 32'(ecnt));
      chk({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
      chk({tag, "_hold"}, 32'(viol), 32'd0);
      chk({tag, "_nwords"}, 32'(bus_log.size() - log0), 32'(n));
      for (int i = 0; i < n && (log0 + i) < bus_log.size(); i++) begin
         chk($sformatf("%s_adr%0d", tag, i), bus_log[log0+i].adr, word_adr(adr, i));
         chk($sformatf("%s_we%0d", tag, i), {31'b0, bus_log[log0+i].we}, {31'b0, wr});
         chk($sformatf("%s_dat%0d", tag, i), bus_log[log0+i].dat,
             wr ? wdata[i] : rdata(word_adr(adr, i)));
      end
      if (!wr) begin
         chk({tag, "_nrd"}, 32'(rdq.size()), 32'(n));
         for (int i = 0; i < n && i < rdq.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), rdq[i], rdata(word_adr(adr, i)));
      end
      if (len == 0) chk({tag, "_no_cyc"}, {31'b0, cyc_seen}, 32'd0);
      if (eerr) chk({tag, "_stb_run"}, 32'(last_run), 32'(TB_TIMEOUT));
   endtask

   // ---------------- stimulus ----------------
   typedef struct {
      bit          wr;
      logic [31:0] adr;
      int          len;
      int          dly;
      int          lim;
      int          rdw;
      bit          eerr;
      int          ecnt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int pulses, exp_p, rsp_cnt_seen, t, n, len, dly, lim;
      bit prev, v, wr;
      logic [31:0] adr;

      vecs[0] = '{1'b1, 32'h01000010, 3, 1, 999, 0, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h02000000, 2, 0, 999, 5, 1'b0, 2};
      vecs[2] = '{1'b0, 32'h00FFFFFF, 2, 0, 999, 0, 1'b0, 2};
      vecs[3] = '{1'b1, 32'h03000000, 4, 0, 2,   0, 1'b1, 2};
      vecs[4] = '{1'b0, 32'h04000100, 0, 0, 999, 0, 1'b0, 0};
      vecs[5] = '{1'b0, 32'h05000000, 1, 7, 999, 0, 1'b0, 1};
      vecs[6] = '{1'b0, 32'h06000000, 3, 8, 999, 0, 1'b1, 0};
      vecs[7] = '{1'b1, 32'h07FFFFFE, 3, 0, 999, 2, 1'b0, 3};

      repeat (3) @(negedge clk);
      chk("reset_outs", {o_cmd_rdy, o_wr_rdy, o_rd_stb, o_rsp_stb, o_rsp_err, o_int_stb,
                         o_m_we, o_m_stb, o_m_cyc, o_m_sel, o_rsp_cnt[5:0], o_m_adr[11:0]}, 32'd0);
      chk("reset_radr", o_rd_dat | o_m_adr | o_m_dat, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_rdy", {31'b0, o_cmd_rdy}, 32'd1);

      for (int i = 0; i < 8; i++)
         run_txn($sformatf("v%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].len, vecs[i].dly,
                 vecs[i].lim, vecs[i].rdw, vecs[i].eerr, vecs[i].ecnt);

      for (int i = 0; i < 12; i++) begin
         wr  = 1'($urandom_range(0, 1));
         adr = $urandom;
         if ($urandom_range(0, 2) == 0) adr[23:0] = 24'hFFFFFF - 24'($urandom_range(0, 3));
         len = $urandom_range(0, 5);
         dly = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(0, 3);
         lim = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 999;
         n   = model_words(len, dly, lim);
         run_txn($sformatf("r%0d", i), wr, adr, len, dly, lim, $urandom_range(0, 3),
                 n < len, n);
      end

      // Reset while a read strobe is outstanding.
      sl_delay = 0;
      sl_lim   = sl_acks;
      issue_cmd(1'b0, 32'h0A000000, 4);
      t = 0;
      while (!o_m_stb && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rst_stb_seen", {31'b0, o_m_stb}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_drop", {30'b0, o_m_cyc, o_m_stb}, 32'd0);
      rsp_cnt_seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 2) rst = 1'b0;
         if (o_rsp_stb) rsp_cnt_seen++;
      end
      chk("rst_no_rsp", 32'(rsp_cnt_seen), 32'd0);
      chk("rst_idle_rdy", {31'b0, o_cmd_rdy}, 32'd1);

      // Level-held interrupt gives a single pulse.
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_m_int = 1'b1;
         #1;
         if (o_int_stb) pulses++;
      end
      chk("int_held_pulses", 32'(pulses), 32'd1);
      @(negedge clk);
      i_m_int = 1'b0;

      // Random interrupt pattern against a rising-edge count.
      @(negedge clk);
      pulses = 0; exp_p = 0; prev = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         v = 1'($urandom_range(0, 1));
         i_m_int = v;
         if (v && !prev) exp_p++;
         prev = v;
         #1;
         if (o_int_stb) pulses++;
      end
      chk("int_rand_pulses", 32'(pulses), 32'(exp_p));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Upstream neighbour of the Wishbone interconnect: the single bus master driving the i_m_* side of the interconnect.
- Accepts host commands (read/write, base address, word count) from a host link framer.
- Issues sequential single-word Wishbone classic cycles and streams write data in / read data out.
- Returns a completion status and forwards slave interrupts to the host as edge events.

Parameters:
- TIMEOUT, 16'd1000, cycles a strobe may wait for ack before the transfer is aborted
- CNT_W, 16, width of the word-count field

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_cmd_stb  in  1  command valid
- o_cmd_rdy  out  1  command accepted when i_cmd_stb && o_cmd_rdy
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_adr  in  32  start address; [31:24] selects slave, [23:0] is offset
- i_cmd_len  in  CNT_W  number of words
- i_wr_stb  in  1  write-data word valid
- i_wr_dat  in  32  write-data word
- o_wr_rdy  out  1  write word consumed when i_wr_stb && o_wr_rdy
- o_rd_stb  out  1  read-data word valid
- o_rd_dat  out  32  read-data word
- i_rd_rdy  in  1  host accepts read word
- o_rsp_stb  out  1  one-cycle completion pulse
- o_rsp_err  out  1  1 = timeout abort (valid with o_rsp_stb)
- o_rsp_cnt  out  CNT_W  words completed (valid with o_rsp_stb)
- o_int_stb  out  1  one-cycle pulse on rising edge of i_m_int
- o_m_we, o_m_stb, o_m_cyc  out  1  Wishbone master controls
- o_m_sel  out  4  byte select
- o_m_adr  out  32  address
- o_m_dat  out  32  write data
- i_m_dat  in  32  read data
- i_m_ack  in  1  slave acknowledge
- i_m_int  in  1  aggregated slave interrupt

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, and the interrupt edge register cleared. Reset asserted mid-transfer drops o_m_cyc/o_m_stb on the same cycle; no response is issued.
- State IDLE:
  - o_cmd_rdy = 1.
  - On accept, latch wr, adr, len; set word count to 0.
  - len == 0: go to DONE (no bus cycle).
  - wr = 1: go to WR_DATA. wr = 0: go to RD_BUS.
- State WR_DATA:
  - o_wr_rdy = 1.
  - On word accept, register the word into o_m_dat and go to WR_BUS.
  - o_wr_rdy is 0 in every other state.
- State WR_BUS:
  - o_m_cyc = o_m_stb = o_m_we = 1, o_m_sel = 4'hF.
  - Ack: drop cyc/stb the next cycle and increment count.
  - If count == len, go to DONE; otherwise go back to WR_DATA.
- State RD_BUS:
  - o_m_cyc = o_m_stb = 1, o_m_we = 0, o_m_sel = 4'hF.
  - Ack: capture i_m_dat into o_rd_dat, drop cyc/stb, go to RD_HOLD.
- State RD_HOLD:
  - o_rd_stb = 1 and o_rd_dat is held until i_rd_rdy.
  - Then increment count; go to DONE if count == len, else to RD_BUS.
  - Backpressure never stalls the bus while a strobe is asserted.
- State DONE:
  - o_rsp_stb pulses for 1 cycle with o_rsp_err and o_rsp_cnt, then return to IDLE.
- Address increment:
  - After each acked word, offset [23:0] increments by 1.
  - Slave select [31:24] never changes; the offset wraps from 24'hFFFFFF to 24'h000000.
- Latency:
  - Strobe asserts the cycle after entering a bus state.
  - A zero-wait slave yields 2 cycles per word plus host handshakes.
- Timeout:
  - A counter clears on strobe rise and increments each cycle stb is high without ack.
  - At TIMEOUT, drop cyc/stb, set err = 1, go to DONE; o_rsp_cnt = words completed before the failing word.
  - An ack arriving in the same cycle the limit is reached wins (word counted, no error).
- Interrupts:
  - Edge detection is independent of state.
  - o_int_stb = i_m_int & ~i_m_int_q.
  - A level held high produces one pulse only.
- Command acceptance: commands presented while not IDLE are not accepted (o_cmd_rdy = 0).

Decomposition:
- Shared package wb_host_pkg holds:
  - state enum (IDLE, WR_DATA, WR_BUS, RD_BUS, RD_HOLD, DONE)
  - SLAVE_SEL_MSB/LSB = 31/24
  - OFFSET_W = 24
  - RSP_OK/RSP_TIMEOUT codes
- One natural sub-module: wb_timeout_counter (clear, enable, expire flag, parameter TIMEOUT).

Test Plan:
- Write len = 3, adr = 32'h01000010, data A, B, C, slave acks after 1 cycle:
  - three cycles at adr 0x01000010/11/12 with o_m_we = 1
  - o_rsp_stb with err = 0, cnt = 3
- Read len = 2, adr = 32'h02000000, i_rd_rdy held low 5 cycles per word:
  - o_rd_dat holds each word
  - no second strobe until the first word is accepted
  - rsp cnt = 2
- Read len = 2, adr = 32'h00FFFFFF:
  - second cycle address is 32'h00000000, not 32'h01000000
- Write len = 4 to slave that never acks after word 2, TIMEOUT = 8:
  - cyc drops after 8 strobe cycles
  - rsp err = 1, cnt = 2
- len = 0 command:
  - no o_m_cyc
  - rsp next cycles with err = 0, cnt = 0
- Assert rst during RD_BUS:
  - o_m_cyc/o_m_stb fall immediately, no o_rsp_stb
- Raise i_m_int and hold it 20 cycles:
  - exactly one o_int_stb pulse
